// File: rtl/alu_result_collector.sv
// alu_result_collector: registers ALU results (opcode, word, flags) into a
// small FIFO and hands them to the writeback/scoreboard consumer over a
// valid/ready handshake. Also keeps a sticky overflow bit and a running count
// of accepted results.
//
// Optional build macro: ALU_RESULT_FLAG_STATS_EN
//   When defined, adds per-flag push counters neg_cnt / ovf_cnt / zero_cnt.
module alu_result_collector #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // upstream (ALU) side
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          alu_opcode,
    input  logic [DATA_W-1:0]        alu_out,
    input  logic                     alu_negative,
    input  logic                     alu_overflow,
    input  logic                     alu_zero,
    // downstream (consumer) side
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OP_W-1:0]          out_opcode,
    output logic [DATA_W-1:0]        out_data,
    output logic [2:0]               out_flags,
    // status / debug
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf_sticky,
    input  logic                     clr_sticky,
`ifdef ALU_RESULT_FLAG_STATS_EN
    output logic [CNT_W-1:0]         neg_cnt,
    output logic [CNT_W-1:0]         ovf_cnt,
    output logic [CNT_W-1:0]         zero_cnt,
`endif
    output logic [CNT_W-1:0]         result_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    // One buffered ALU result.
    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] data;
        logic              negative;
        logic              overflow;
        logic              zero;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            in_entry;
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic              push;
    logic              pop;

    // Handshake qualifiers come from registered occupancy only, so there is
    // no combinational path from out_ready to in_ready (a full FIFO refuses
    // a push even when the consumer is popping in the same cycle).
    assign in_ready  = (level_q != FULL_LVL);
    assign out_valid = (level_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign level     = level_q;

    // Pack the incoming ALU sample into a storage entry.
    always_comb begin
        in_entry          = '0;
        in_entry.opcode   = alu_opcode;
        in_entry.data     = alu_out;
        in_entry.negative = alu_negative;
        in_entry.overflow = alu_overflow;
        in_entry.zero     = alu_zero;
    end

    // Storage array; contents are only meaningful where level says so, so it
    // carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // Write/read pointers; DEPTH is a power of two so they wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Occupancy: EMPTY (0), PARTIAL, FULL (DEPTH); push+pop together holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Head entry drives the outputs directly; forced to zero while empty so
    // stale storage never leaks out.
    always_comb begin
        head       = mem[rd_ptr];
        out_opcode = '0;
        out_data   = '0;
        out_flags  = '0;
        if (out_valid) begin
            out_opcode = head.opcode;
            out_data   = head.data;
            out_flags  = {head.negative, head.overflow, head.zero};
        end
    end

    // Sticky overflow: a new overflow push outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (push && alu_overflow) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end

    // Running count of accepted results, wraps modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_cnt <= '0;
        end else if (push) begin
            result_cnt <= result_cnt + CNT_W'(1);
        end
    end

`ifdef ALU_RESULT_FLAG_STATS_EN
    logic neg_hit;
    logic ovf_hit;
    logic zero_hit;

    assign neg_hit  = push & alu_negative;
    assign ovf_hit  = push & alu_overflow;
    assign zero_hit = push & alu_zero;

    // Per-flag push counters; a clear restarts from the current cycle, so a
    // flagged push during a clear leaves the counter at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_cnt  <= '0;
            ovf_cnt  <= '0;
            zero_cnt <= '0;
        end else if (clr_sticky) begin
            neg_cnt  <= CNT_W'(neg_hit);
            ovf_cnt  <= CNT_W'(ovf_hit);
            zero_cnt <= CNT_W'(zero_hit);
        end else begin
            if (neg_hit)  neg_cnt  <= neg_cnt  + CNT_W'(1);
            if (ovf_hit)  ovf_cnt  <= ovf_cnt  + CNT_W'(1);
            if (zero_hit) zero_cnt <= zero_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
